// File: rtl/vga_tile_display_if.sv
// vga_tile_display_if: bundles the tile-map read port and the VGA DAC outputs.
//   vaddr        tile map read address (display -> memory)
//   vdata        tile byte, RD_LAT clocks after vaddr (memory -> display)
//   VGA_R/G/B    pixel colour, VGA_BITS per channel
//   VGA_HS_O/VS_O sync outputs
//   frame_start  one-clock pulse on the first active pixel of a frame
// master: the display controller. slave: memory / DAC side.
interface vga_tile_display_if #(
   parameter int ADDR_W   = 9,
   parameter int VGA_BITS = 8
);
   logic [ADDR_W-1:0]   vaddr;
   logic [7:0]          vdata;
   logic [VGA_BITS-1:0] VGA_R, VGA_G, VGA_B;
   logic                VGA_HS_O, VGA_VS_O, frame_start;

   modport master (output vaddr, VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O, frame_start,
                   input  vdata);
   modport slave  (input  vaddr, VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O, frame_start,
                   output vdata);
endinterface

// File: rtl/vga_tile_display.sv
// vga_tile_display: programmable-timing VGA controller that scans a tile map in
// memory and expands each tile byte to RGB (grayscale or RGB332).
// Ports:
//   clk    pixel clock
//   reset  asynchronous, active-high
//   vif    vga_tile_display_if.master (vaddr/vdata memory port, VGA outputs)
// Every output (colour, syncs, frame_start) lags the counters by RD_LAT+2
// clocks; vaddr lags by 1 clock.
// Optional: define VGA_GRID_EN to draw mid-gray grid lines on tile edges.
module vga_tile_display #(
   parameter int VGA_BITS   = 8,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int TILE_SHIFT = 5,
   parameter int GRID_W     = 20,
   parameter int GRID_H     = 15,
   parameter int BASE_ADDR  = 212,
   parameter int ADDR_W     = 9,
   parameter int RD_LAT     = 1,
   parameter int COLOR_MODE = 0
) (
   input logic                clk,
   input logic                reset,
   vga_tile_display_if.master vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic POL = (SYNC_POL != 0);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [31:0] TMASK = (32'd1 << TILE_SHIFT) - 32'd1;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic ing;
`ifdef VGA_GRID_EN
      logic grid;
`endif
      logic frm;
   } ctl_t;

   // ---- stage 0: counters ----
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == HW'(H_TOTAL-1)) begin
         hcnt <= '0;
         vcnt <= (vcnt == VW'(V_TOTAL-1)) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end

   logic [31:0] h32, v32, col, row;
   logic        in_grid0;
   assign h32 = 32'(hcnt);
   assign v32 = 32'(vcnt);
   assign col = h32 >> TILE_SHIFT;
   assign row = v32 >> TILE_SHIFT;
   assign in_grid0 = (col < 32'(GRID_W)) && (row < 32'(GRID_H));

   // row*GRID_W as a sum of shifted copies over the set bits of the constant,
   // so no multiplier is inferred. Truncation to ADDR_W gives the wrap-around.
   logic [ADDR_W-1:0] row_mul, addr0;
   always_comb begin
      row_mul = '0;
      for (int i = 0; i < 31; i++)
         if (GRID_W[i]) row_mul = row_mul + ADDR_W'(row << i);
   end
   assign addr0 = in_grid0 ? BASE + ADDR_W'(col) + row_mul : BASE;

   ctl_t ctl0;
   always_comb begin
      ctl0      = '0;
      ctl0.de   = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
      ctl0.hs   = (h32 >= 32'(H_ACTIVE + H_FP)) && (h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
      ctl0.vs   = (v32 >= 32'(V_ACTIVE + V_FP)) && (v32 < 32'(V_ACTIVE + V_FP + V_SYNC));
      ctl0.ing  = in_grid0;
`ifdef VGA_GRID_EN
      ctl0.grid = in_grid0 && (((h32 & TMASK) == 32'd0) || ((v32 & TMASK) == 32'd0));
`endif
      ctl0.frm  = (hcnt == '0) && (vcnt == '0);
   end

   // ---- stage 1: address register + control delay line ----
   // ctl_pipe[RD_LAT] lines up with vdata returned for the same counter value.
   ctl_t [RD_LAT:0] ctl_pipe;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         vif.vaddr <= BASE;
         ctl_pipe  <= '0;
      end else begin
         vif.vaddr <= addr0;
         ctl_pipe  <= {ctl_pipe[RD_LAT-1:0], ctl0};
      end

   // ---- output stage: colour expansion ----
   function automatic logic [VGA_BITS-1:0] rep3(input logic [2:0] v);
      logic [VGA_BITS-1:0] r;
      for (int i = 0; i < VGA_BITS; i++) r[VGA_BITS-1-i] = v[2 - (i % 3)];
      return r;
   endfunction

   function automatic logic [VGA_BITS-1:0] rep2(input logic [1:0] v);
      logic [VGA_BITS-1:0] r;
      for (int i = 0; i < VGA_BITS; i++) r[VGA_BITS-1-i] = v[1 - (i % 2)];
      return r;
   endfunction

   ctl_t cd;
   logic [VGA_BITS-1:0] r_n, g_n, b_n, gray;
   assign cd   = ctl_pipe[RD_LAT];
   assign gray = VGA_BITS'({vif.vdata[3:0], {VGA_BITS{1'b0}}} >> 4);

   always_comb begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
      if (cd.de && cd.ing) begin
         if (COLOR_MODE == 1) begin
            r_n = rep3(vif.vdata[7:5]);
            g_n = rep3(vif.vdata[4:2]);
            b_n = rep2(vif.vdata[1:0]);
         end else begin
            r_n = gray;
            g_n = gray;
            b_n = gray;
         end
`ifdef VGA_GRID_EN
         if (cd.grid) begin
            r_n = VGA_BITS'(1) << (VGA_BITS-1);
            g_n = VGA_BITS'(1) << (VGA_BITS-1);
            b_n = VGA_BITS'(1) << (VGA_BITS-1);
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         vif.VGA_R       <= '0;
         vif.VGA_G       <= '0;
         vif.VGA_B       <= '0;
         vif.VGA_HS_O    <= ~POL;
         vif.VGA_VS_O    <= ~POL;
         vif.frame_start <= 1'b0;
      end else begin
         vif.VGA_R       <= r_n;
         vif.VGA_G       <= g_n;
         vif.VGA_B       <= b_n;
         vif.VGA_HS_O    <= cd.hs ~^ POL;
         vif.VGA_VS_O    <= cd.vs ~^ POL;
         vif.frame_start <= cd.frm;
      end
endmodule

// File: doc/vga_tile_display.md
# vga_tile_display

Parametrised VGA tile-display controller and successor to the fixed 640x480 grayscale scanner. Generates programmable sync timing and scans a tile map in data memory at a configurable base address, tile size and grid size. It compensates a configurable memory read latency so pixels, sync and blanking stay aligned, and expands each tile byte to RGB in grayscale or RGB332 mode. It sits between the RISC-V data memory (read-only port) and the board VGA DAC.

## Interface
- VGA_BITS, 8: DAC bits per colour channel (≥4).
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixel clocks.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- SYNC_POL, 0: asserted sync level; 0 means active-low.
- TILE_SHIFT, 5: tile edge is 2^TILE_SHIFT pixels.
- GRID_W, 20 / GRID_H, 15: tile map columns and rows.
- BASE_ADDR, 212: map address of tile (0,0).
- ADDR_W, 9: memory address width.
- RD_LAT, 1: memory read latency in clocks (1–3).
- COLOR_MODE, 0: 0 = grayscale vdata[3:0]; 1 = RGB332.
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- vdata  in  8  tile byte, valid RD_LAT clocks after vaddr.
- vaddr  out  ADDR_W  tile map read address.
- VGA_R, VGA_G, VGA_B  out  VGA_BITS each  pixel colour.
- VGA_HS_O, VGA_VS_O  out  1  sync outputs at SYNC_POL polarity.
- frame_start  out  1  one-clock pulse, aligned with the first active pixel of each frame.

## Operation
- Counters: hcnt runs 0..H_TOTAL-1 with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. It wraps to 0; vcnt increments on that wrap and runs 0..V_TOTAL-1, wrapping likewise. There is no extra count at the end of a line.
- Stage 0 (counters) produces de0, hs0, vs0, in_grid0 and the address:
  - de0 = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs0 asserted for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vs0 asserted for the analogous V range.
  - col = hcnt>>TILE_SHIFT, row = vcnt>>TILE_SHIFT.
  - in_grid0 = col<GRID_W && row<GRID_H.
  - Address = BASE_ADDR + col + row*GRID_W, truncated to ADDR_W (wrap-around modulo 2^ADDR_W).
  - If !in_grid0, the address is BASE_ADDR.
- Stage 1 registers vaddr. Control bits (de, hs, vs, in_grid, grid-line flag, frame flag) enter a shift pipeline RD_LAT+1 deep.
- Output stage registers colour and syncs when vdata is valid.
  - Pixel is black unless delayed de && in_grid.
  - COLOR_MODE 0: each channel = {vdata[3:0], zero-fill to VGA_BITS}.
  - COLOR_MODE 1: R = vdata[7:5], G = vdata[4:2], B = vdata[1:0]. Each is left-justified and MSB-replicated to VGA_BITS.
- Sync outputs: VGA_HS_O = delayed hs XNOR SYNC_POL; VGA_VS_O likewise.
- frame_start is set when stage-0 hcnt==0 && vcnt==0, delayed through the same pipeline.
- The multiply by GRID_W is a constant multiply; synthesis must not infer a DSP. Shift-add is acceptable.

## Timing
- Reset (asynchronous):
  - hcnt = vcnt = 0, all pipeline bits 0.
  - vaddr = BASE_ADDR, VGA_R/G/B = 0, frame_start = 0.
  - VGA_HS_O = VGA_VS_O = ~SYNC_POL (deasserted).
- Reset asserted mid-frame forces all of the above immediately. After release the first clock edge sees hcnt=0, vcnt=0.
- Latency from counter value to vaddr: 1 clock.
- Latency from counter value to all outputs (colour, syncs, frame_start): RD_LAT+2 clocks. Every output shares this latency, so the pixel-to-sync relationship matches the nominal timing exactly.
- Frame period = H_TOTAL*V_TOTAL clocks. frame_start fires exactly once per frame.
- At the hcnt wrap, vcnt updates on the same edge. At a simultaneous hcnt and vcnt wrap, both go to 0.

## Configuration
- VGA_GRID_EN defined:
  - A pixel whose in-tile x offset (hcnt[TILE_SHIFT-1:0]) or y offset is 0 and which is inside the grid outputs mid-gray on all channels (MSB=1, rest 0), overriding tile colour.
  - The flag is computed at stage 0 and delayed through the pipeline.
- VGA_GRID_EN undefined: no grid-line logic exists; tile colour is output unmodified.

## Test plan
- Reset then free-run with defaults:
  - HS period 800 clocks, HS low for exactly 96 clocks.
  - VS period 420000 clocks, VS low for 2 lines.
  - One frame_start per 420000 clocks.
- Address sweep, defaults, memory model RD_LAT=1: vaddr = 212 at (0,0), 231 at hcnt 639 vcnt 0, 232 at hcnt 0 vcnt 32, 511 at tile (19,14).
- Alignment: memory returns vdata = vaddr[7:0]. COLOR_MODE 0, RD_LAT=3. The pixel for counter (64,0) appears exactly 5 clocks later with value {4'h6,4'h0} (vaddr 214). Blanking starts on the same clock as the counter reaches hcnt=640+5.
- RGB332: vdata=8'hE3 gives R=8'hFF, G=8'h00, B=8'hFF. vdata=8'h49 gives R=8'h49, G=8'h49, B=8'h55.
- Small grid: H_ACTIVE 64, GRID_W 1, TILE_SHIFT 5, with vdata=8'hFF. Pixels at hcnt ≥ 32 are black; vaddr there equals BASE_ADDR.
- Reset pulse at hcnt 300 vcnt 200: outputs go to reset values in the same clock. After release, the next frame_start arrives RD_LAT+2 clocks later. With VGA_GRID_EN, pixel (32,5) outputs 8'h80 on all channels.
